// File: rtl/serial_subtractor_32bit.sv
// serial_subtractor_32bit: slice-serial A - B - Bin with start/busy/done handshake
module serial_subtractor_32bit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             ovf
);
  localparam int N  = WIDTH / SLICE;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic             brw;
  logic             a_msb;
  logic             b_msb;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [SLICE:0]   s;
  logic [WIDTH-1:0] res_nxt;
  always_comb begin
    s       = {1'b0, a_sh[SLICE-1:0]} - {1'b0, b_sh[SLICE-1:0]} - {{SLICE{1'b0}}, brw};
    res_nxt = {s[SLICE-1:0], res[WIDTH-1:SLICE]};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      brw   <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      Diff  <= '0;
      Bout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> SLICE;
      b_sh <= b_sh >> SLICE;
      res  <= res_nxt;
      brw  <= s[SLICE];
      cnt  <= cnt + CW'(1);
      if (cnt == CW'(N - 1)) begin
        Diff  <= res_nxt;
        Bout  <= s[SLICE];
        ovf   <= (a_msb != b_msb) && (res_nxt[WIDTH-1] != a_msb);
        state <= FIN;
        busy  <= 1'b0;
        done  <= 1'b1;
      end
    end else begin
      // IDLE and FIN both accept a new request, giving back-to-back issue
      done <= 1'b0;
      busy <= start;
      if (start) begin
        a_sh  <= A;
        b_sh  <= B;
        a_msb <= A[WIDTH-1];
        b_msb <= B[WIDTH-1];
        brw   <= Bin;
        cnt   <= '0;
        res   <= '0;
        state <= RUN;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor_32bit.sv
// tb_serial_subtractor_32bit: directed checks of the slice-serial subtractor
module tb_serial_subtractor_32bit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Bin = 1'b0;
  logic        busy, done, Bout, ovf;
  logic [31:0] Diff;
  int checks = 0;
  int errs = 0;

  serial_subtractor_32bit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Bin(Bin),
    .busy(busy), .done(done), .Diff(Diff), .Bout(Bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // done is expected at lat == 9 (accept edge plus 8 RUN edges); bcnt counts busy samples
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                        output int lat, output int bcnt);
    @(negedge clk);
    A = a; B = b; Bin = bin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    bcnt = 0;
    while (done !== 1'b1 && lat < 30) begin
      bcnt += (busy === 1'b1) ? 1 : 0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    int lat, bcnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, Diff, Bout, ovf} !== 36'd0) begin
      errs++;
      $display("FAIL reset_init: got busy=%b done=%b Diff=%h Bout=%b ovf=%b, want all 0", busy, done, Diff, Bout, ovf);
    end
    run_op(32'd10, 32'd5, 1'b0, lat, bcnt);
    checks++;
    if (Diff !== 32'd5) begin
      errs++;
      $display("FAIL reset_preop: got Diff=%h, want 5", Diff);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, Diff, Bout, ovf} !== 36'd0) begin
      errs++;
      $display("FAIL reset_async: got busy=%b done=%b Diff=%h Bout=%b ovf=%b, want all 0", busy, done, Diff, Bout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_arith();
    logic [31:0] ta [9] = '{32'd10, 32'd100, 32'd0, 32'h80000000, 32'h7FFFFFFF,
                           32'h12345678, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h00010000};
    logic [31:0] tb [9] = '{32'd5, 32'd200, 32'd0, 32'd1, 32'hFFFFFFFF,
                           32'h12345678, 32'd0, 32'h12345678, 32'd1};
    logic        tc [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] td [9] = '{32'd4, 32'hFFFFFF9C, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000,
                           32'hFFFFFFFF, 32'hFFFFFFFF, 32'hCC796877, 32'h0000FFFF};
    logic        tbo [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        tov [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      int lat, bcnt;
      logic [32:0] m;
      run_op(ta[i], tb[i], tc[i], lat, bcnt);
      m = {1'b0, ta[i]} - {1'b0, tb[i]} - {32'd0, tc[i]};
      checks++;
      if (lat !== 9 || bcnt !== 8) begin
        errs++;
        $display("FAIL arith%0d_latency: got lat=%0d busy_cycles=%0d, want 9/8", i, lat, bcnt);
      end
      checks++;
      if (Diff !== td[i] || Bout !== tbo[i] || ovf !== tov[i]) begin
        errs++;
        $display("FAIL arith%0d_result: got Diff=%h Bout=%b ovf=%b, want Diff=%h Bout=%b ovf=%b",
                 i, Diff, Bout, ovf, td[i], tbo[i], tov[i]);
      end
      checks++;
      if ({Bout, Diff} !== m) begin
        errs++;
        $display("FAIL arith%0d_model: got %h, want %h", i, {Bout, Diff}, m);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || Diff !== td[i]) begin
        errs++;
        $display("FAIL arith%0d_hold: got done=%b Diff=%h, want done=0 Diff=%h", i, done, Diff, td[i]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    @(negedge clk);
    A = 32'd10; B = 32'd5; Bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    A = 32'h55555555; B = 32'h12; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errs++;
      $display("FAIL busy_ignore_state: got busy=%b done=%b, want 1/0", busy, done);
    end
    lat = 4;
    while (done !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 9 || Diff !== 32'd4 || Bout !== 1'b0) begin
      errs++;
      $display("FAIL busy_ignore_result: got lat=%0d Diff=%h Bout=%b, want 9 00000004 0", lat, Diff, Bout);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL busy_ignore_idle: got busy=%b done=%b, want 0/0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    A = 32'd100; B = 32'd200; Bin = 1'b0; start = 1'b1;
    lat = 0;
    while (done !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 9 || Diff !== 32'hFFFFFF9C || Bout !== 1'b1) begin
      errs++;
      $display("FAIL b2b_first: got lat=%0d Diff=%h Bout=%b, want 9 ffffff9c 1", lat, Diff, Bout);
    end
    A = 32'h80000000; B = 32'd1; Bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errs++;
      $display("FAIL b2b_accept: got busy=%b done=%b, want 1/0", busy, done);
    end
    lat = 1;
    while (done !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 9 || Diff !== 32'h7FFFFFFF || Bout !== 1'b0 || ovf !== 1'b1) begin
      errs++;
      $display("FAIL b2b_second: got lat=%0d Diff=%h Bout=%b ovf=%b, want 9 7fffffff 0 1", lat, Diff, Bout, ovf);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bcnt, seen;
    @(negedge clk);
    A = 32'd7; B = 32'd3; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, Diff, Bout, ovf} !== 36'd0) begin
      errs++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b Diff=%h Bout=%b ovf=%b, want all 0", busy, done, Diff, Bout, ovf);
    end
    seen = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      seen += (done !== 1'b0 || busy !== 1'b0) ? 1 : 0;
    end
    checks++;
    if (seen !== 0 || Diff !== 32'd0) begin
      errs++;
      $display("FAIL reset_mid_quiet: got activity=%0d Diff=%h, want 0 00000000", seen, Diff);
    end
    run_op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, lat, bcnt);
    checks++;
    if (lat !== 9 || Diff !== 32'h80000000 || Bout !== 1'b1 || ovf !== 1'b1) begin
      errs++;
      $display("FAIL reset_mid_after: got lat=%0d Diff=%h Bout=%b ovf=%b, want 9 80000000 1 1", lat, Diff, Bout, ovf);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule
